ocx_tlx_fbist_cmd_arb: RTL and testbench

Downstream stage of the fbist AXI transaction FIFO block. It consumes that block's OpenCAPI write-command and read-command channels, arbitrates round-robin between them, and gates each grant on TLX command and data credits. Each granted command is translated to a TL opcode and data length and held in a single output register with a valid/ready handshake toward the TLX command interface.

---
 rtl/ocx_tlx_fbist_cmd_arb_if.sv | 62 ++++++
 rtl/ocx_tlx_fbist_cmd_arb.sv | 126 ++++++++++++
 tb/tb_ocx_tlx_fbist_cmd_arb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ocx_tlx_fbist_cmd_arb_if.sv
// Bundle between the fbist AXI transaction FIFO command channels, the TLX
// command interface and the credit counters of ocx_tlx_fbist_cmd_arb.
interface ocx_tlx_fbist_cmd_arb_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 12
);
    logic [ID_WIDTH-1:0]     oc_write_command_ready_id;
    logic [ADDR_WIDTH-1:0]   oc_write_command_ready_address;
    logic [7:0]              oc_write_command_ready_length;
    logic [2:0]              oc_write_command_ready_size;
    logic [DATA_WIDTH-1:0]   oc_write_command_ready_data;
    logic [DATA_WIDTH-1:0]   oc_write_command_ready_data2;
    logic                    oc_write_command_ready;
    logic                    oc_write_command_taken;
    logic [ID_WIDTH-1:0]     oc_read_command_ready_id;
    logic [ADDR_WIDTH-1:0]   oc_read_command_ready_address;
    logic [7:0]              oc_read_command_ready_length;
    logic [2:0]              oc_read_command_ready_size;
    logic                    oc_read_command_ready;
    logic                    oc_read_command_taken;
    logic                    tlx_cmd_valid;
    logic                    tlx_cmd_ready;
    logic [7:0]              tlx_cmd_opcode;
    logic [15:0]             tlx_cmd_capptag;
    logic [ADDR_WIDTH-1:0]   tlx_cmd_ea;
    logic [1:0]              tlx_cmd_dl;
    logic [2*DATA_WIDTH-1:0] tlx_cmd_data;
    logic                    tlx_cmd_credit_return;
    logic [1:0]              tlx_data_credit_return;
    logic                    cmd_error;
    logic [7:0]              cmd_credits;
    logic [7:0]              data_credits;

    modport slave (
        input  oc_write_command_ready_id, oc_write_command_ready_address,
               oc_write_command_ready_length, oc_write_command_ready_size,
               oc_write_command_ready_data, oc_write_command_ready_data2,
               oc_write_command_ready,
               oc_read_command_ready_id, oc_read_command_ready_address,
               oc_read_command_ready_length, oc_read_command_ready_size,
               oc_read_command_ready,
               tlx_cmd_ready, tlx_cmd_credit_return, tlx_data_credit_return,
        output oc_write_command_taken, oc_read_command_taken,
               tlx_cmd_valid, tlx_cmd_opcode, tlx_cmd_capptag, tlx_cmd_ea,
               tlx_cmd_dl, tlx_cmd_data, cmd_error, cmd_credits, data_credits
    );

    modport master (
        output oc_write_command_ready_id, oc_write_command_ready_address,
               oc_write_command_ready_length, oc_write_command_ready_size,
               oc_write_command_ready_data, oc_write_command_ready_data2,
               oc_write_command_ready,
               oc_read_command_ready_id, oc_read_command_ready_address,
               oc_read_command_ready_length, oc_read_command_ready_size,
               oc_read_command_ready,
               tlx_cmd_ready, tlx_cmd_credit_return, tlx_data_credit_return,
        input  oc_write_command_taken, oc_read_command_taken,
               tlx_cmd_valid, tlx_cmd_opcode, tlx_cmd_capptag, tlx_cmd_ea,
               tlx_cmd_dl, tlx_cmd_data, cmd_error, cmd_credits, data_credits
    );
endinterface

// File: rtl/ocx_tlx_fbist_cmd_arb.sv
// Round-robin write/read command arbiter in front of the TLX command port,
// gated on TLX command/data credits, with a single registered output slot.
module ocx_tlx_fbist_cmd_arb #(
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 512,
    parameter int ID_WIDTH         = 12,
    parameter int CMD_CREDIT_INIT  = 8,
    parameter int DATA_CREDIT_INIT = 16
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_aresetn,
    ocx_tlx_fbist_cmd_arb_if.slave  bus
);
    localparam logic [7:0] OP_RD_MEM    = 8'h20;
    localparam logic [7:0] OP_WRITE_MEM = 8'h81;

    typedef enum logic {GNT_WR, GNT_RD} gnt_e;

    typedef struct packed {
        logic [7:0]              opcode;
        logic [15:0]             capptag;
        logic [ADDR_WIDTH-1:0]   ea;
        logic [1:0]              dl;
        logic [2*DATA_WIDTH-1:0] data;
    } tlx_cmd_t;

    tlx_cmd_t   pl_q, pl_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    gnt_e       last_q, last_d;
    logic [7:0] cmd_cr_q, cmd_cr_d, data_cr_q, data_cr_d;
    logic [7:0] cmd_use, data_use;
    logic [8:0] cmd_sum, data_sum;

    logic       wr_legal, rd_legal, wr_elig, rd_elig, load_ok, gnt_wr, gnt_rd;
    logic [7:0] wr_beats;

    // Only 64B-size commands of one or two beats map onto a TL opcode.
    assign wr_legal = (bus.oc_write_command_ready_size == 3'd6) &&
                      (bus.oc_write_command_ready_length[7:1] == 7'd0);
    assign rd_legal = (bus.oc_read_command_ready_size == 3'd6) &&
                      (bus.oc_read_command_ready_length[7:1] == 7'd0);
    assign wr_beats = bus.oc_write_command_ready_length[0] ? 8'd2 : 8'd1;

    assign wr_elig = bus.oc_write_command_ready &
                     (~wr_legal | ((cmd_cr_q != 8'd0) & (data_cr_q >= wr_beats)));
    assign rd_elig = bus.oc_read_command_ready & (~rd_legal | (cmd_cr_q != 8'd0));
    assign load_ok = ~valid_q | bus.tlx_cmd_ready;

    // Reset term keeps the pop pulses quiet while the block is held in reset.
    assign gnt_wr = s0_axi_aresetn & load_ok & wr_elig & (~rd_elig | (last_q == GNT_RD));
    assign gnt_rd = s0_axi_aresetn & load_ok & rd_elig & ~gnt_wr;

    always_comb begin
        valid_d  = valid_q & ~bus.tlx_cmd_ready;
        pl_d     = pl_q;
        err_d    = 1'b0;
        last_d   = last_q;
        cmd_use  = 8'd0;
        data_use = 8'd0;
        if (gnt_wr) begin
            last_d = GNT_WR;
            if (wr_legal) begin
                valid_d      = 1'b1;
                pl_d.opcode  = OP_WRITE_MEM;
                pl_d.capptag = 16'(bus.oc_write_command_ready_id);
                pl_d.ea      = bus.oc_write_command_ready_address;
                pl_d.dl      = bus.oc_write_command_ready_length[0] ? 2'b10 : 2'b01;
                pl_d.data    = {bus.oc_write_command_ready_data2, bus.oc_write_command_ready_data};
                cmd_use      = 8'd1;
                data_use     = wr_beats;
            end else begin
                err_d = 1'b1;
            end
        end else if (gnt_rd) begin
            last_d = GNT_RD;
            if (rd_legal) begin
                valid_d      = 1'b1;
                pl_d.opcode  = OP_RD_MEM;
                pl_d.capptag = 16'(bus.oc_read_command_ready_id);
                pl_d.ea      = bus.oc_read_command_ready_address;
                pl_d.dl      = bus.oc_read_command_ready_length[0] ? 2'b10 : 2'b01;
                pl_d.data    = '0;
                cmd_use      = 8'd1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Consume and return net in one step; eligibility rules out underflow.
    assign cmd_sum   = {1'b0, cmd_cr_q} - {1'b0, cmd_use} + {8'd0, bus.tlx_cmd_credit_return};
    assign data_sum  = {1'b0, data_cr_q} - {1'b0, data_use} + {7'd0, bus.tlx_data_credit_return};
    assign cmd_cr_d  = cmd_sum[8]  ? 8'hFF : cmd_sum[7:0];
    assign data_cr_d = data_sum[8] ? 8'hFF : data_sum[7:0];

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            valid_q   <= 1'b0;
            pl_q      <= '0;
            err_q     <= 1'b0;
            last_q    <= GNT_RD;
            cmd_cr_q  <= 8'(CMD_CREDIT_INIT);
            data_cr_q <= 8'(DATA_CREDIT_INIT);
        end else begin
            valid_q   <= valid_d;
            pl_q      <= pl_d;
            err_q     <= err_d;
            last_q    <= last_d;
            cmd_cr_q  <= cmd_cr_d;
            data_cr_q <= data_cr_d;
        end
    end

    assign bus.oc_write_command_taken = gnt_wr;
    assign bus.oc_read_command_taken  = gnt_rd;
    assign bus.tlx_cmd_valid          = valid_q;
    assign bus.tlx_cmd_opcode         = pl_q.opcode;
    assign bus.tlx_cmd_capptag        = pl_q.capptag;
    assign bus.tlx_cmd_ea             = pl_q.ea;
    assign bus.tlx_cmd_dl             = pl_q.dl;
    assign bus.tlx_cmd_data           = pl_q.data;
    assign bus.cmd_error              = err_q;
    assign bus.cmd_credits            = cmd_cr_q;
    assign bus.data_credits           = data_cr_q;
endmodule

// File: tb/tb_ocx_tlx_fbist_cmd_arb.sv
// Directed bench for ocx_tlx_fbist_cmd_arb: arbitration order, credit gating,
// illegal-command drop, output hold under stall and async reset.
module tb_ocx_tlx_fbist_cmd_arb;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int IW = 12;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ocx_tlx_fbist_cmd_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    ocx_tlx_fbist_cmd_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .CMD_CREDIT_INIT(8), .DATA_CREDIT_INIT(16)
    ) dut (
        .s0_axi_aclk    (clk),
        .s0_axi_aresetn (rst_n),
        .bus            (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.oc_write_command_ready_id      = '0;
        bus.oc_write_command_ready_address = '0;
        bus.oc_write_command_ready_length  = 8'd0;
        bus.oc_write_command_ready_size    = 3'd6;
        bus.oc_write_command_ready_data    = '0;
        bus.oc_write_command_ready_data2   = '0;
        bus.oc_write_command_ready         = 1'b0;
        bus.oc_read_command_ready_id       = '0;
        bus.oc_read_command_ready_address  = '0;
        bus.oc_read_command_ready_length   = 8'd0;
        bus.oc_read_command_ready_size     = 3'd6;
        bus.oc_read_command_ready          = 1'b1;   // pending during reset: no pop allowed
        bus.tlx_cmd_ready                  = 1'b1;
        bus.tlx_cmd_credit_return          = 1'b0;
        bus.tlx_data_credit_return         = 2'd0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.tlx_cmd_valid), 64'd0);
        chk("rst_rd_taken", 64'(bus.oc_read_command_taken), 64'd0);
        chk("rst_wr_taken", 64'(bus.oc_write_command_taken), 64'd0);
        chk("rst_err", 64'(bus.cmd_error), 64'd0);
        chk("rst_cmd_cr", 64'(bus.cmd_credits), 64'd8);
        chk("rst_data_cr", 64'(bus.data_credits), 64'd16);
        chk("rst_opcode", 64'(bus.tlx_cmd_opcode), 64'd0);
        chk("rst_data", 64'(bus.tlx_cmd_data), 64'd0);
        bus.oc_read_command_ready = 1'b0;
        rst_n = 1'b1;

        // single legal read
        cyc();
        bus.oc_read_command_ready_id      = 12'h05A;
        bus.oc_read_command_ready_address = 64'h1000;
        bus.oc_read_command_ready         = 1'b1;
        #1;
        chk("rd_taken", 64'(bus.oc_read_command_taken), 64'd1);
        chk("rd_wr_taken", 64'(bus.oc_write_command_taken), 64'd0);
        chk("rd_valid_n", 64'(bus.tlx_cmd_valid), 64'd0);
        cyc();
        bus.oc_read_command_ready = 1'b0;
        #1;
        chk("rd_valid", 64'(bus.tlx_cmd_valid), 64'd1);
        chk("rd_opcode", 64'(bus.tlx_cmd_opcode), 64'h20);
        chk("rd_capptag", 64'(bus.tlx_cmd_capptag), 64'h005A);
        chk("rd_dl", 64'(bus.tlx_cmd_dl), 64'd1);
        chk("rd_ea", 64'(bus.tlx_cmd_ea), 64'h1000);
        chk("rd_data", 64'(bus.tlx_cmd_data), 64'd0);
        chk("rd_cmd_cr", 64'(bus.cmd_credits), 64'd7);
        chk("rd_taken_off", 64'(bus.oc_read_command_taken), 64'd0);

        // two-beat write
        bus.oc_write_command_ready_id      = 12'h007;
        bus.oc_write_command_ready_address = 64'h2000;
        bus.oc_write_command_ready_length  = 8'd1;
        bus.oc_write_command_ready_data    = 32'hAAAA0001;
        bus.oc_write_command_ready_data2   = 32'hBBBB0002;
        bus.oc_write_command_ready         = 1'b1;
        #1;
        chk("wr_taken", 64'(bus.oc_write_command_taken), 64'd1);
        cyc();
        bus.oc_write_command_ready = 1'b0;
        #1;
        chk("wr_opcode", 64'(bus.tlx_cmd_opcode), 64'h81);
        chk("wr_dl", 64'(bus.tlx_cmd_dl), 64'd2);
        chk("wr_data", 64'(bus.tlx_cmd_data), 64'hBBBB0002_AAAA0001);
        chk("wr_capptag", 64'(bus.tlx_cmd_capptag), 64'h0007);
        chk("wr_data_cr", 64'(bus.data_credits), 64'd14);
        chk("wr_cmd_cr", 64'(bus.cmd_credits), 64'd6);

        // round robin from reset: W,R,W,R,W,R
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.oc_write_command_ready_length = 8'd0;
        bus.oc_write_command_ready        = 1'b1;
        bus.oc_read_command_ready         = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_wr%0d", i), 64'(bus.oc_write_command_taken), 64'((i % 2) == 0));
            chk($sformatf("rr_rd%0d", i), 64'(bus.oc_read_command_taken), 64'((i % 2) == 1));
            @(posedge clk);
        end
        #1;
        bus.oc_write_command_ready = 1'b0;
        bus.oc_read_command_ready  = 1'b0;
        #1;
        chk("rr_cmd_cr", 64'(bus.cmd_credits), 64'd2);
        chk("rr_data_cr", 64'(bus.data_credits), 64'd13);
        chk("rr_last_op", 64'(bus.tlx_cmd_opcode), 64'h20);

        // drain command credits, then return them
        bus.oc_read_command_ready = 1'b1;
        #1;
        chk("drain_2", 64'(bus.oc_read_command_taken), 64'd1);
        cyc();
        chk("drain_1", 64'(bus.oc_read_command_taken), 64'd1);
        cyc();
        chk("drain_cr0", 64'(bus.cmd_credits), 64'd0);
        chk("drain_block", 64'(bus.oc_read_command_taken), 64'd0);
        cyc();
        chk("drain_block2", 64'(bus.oc_read_command_taken), 64'd0);
        bus.tlx_cmd_credit_return = 1'b1;
        cyc();
        chk("ret_cr1", 64'(bus.cmd_credits), 64'd1);
        chk("ret_taken", 64'(bus.oc_read_command_taken), 64'd1);
        cyc();
        bus.tlx_cmd_credit_return = 1'b0;
        bus.oc_read_command_ready = 1'b0;
        #1;
        chk("net_cr", 64'(bus.cmd_credits), 64'd1);

        // data-credit stall: bring data credits to 1 with cmd credits held level
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.oc_write_command_ready_length = 8'd1;
        bus.oc_write_command_ready        = 1'b1;
        bus.tlx_cmd_credit_return         = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk($sformatf("dfill%0d", i), 64'(bus.oc_write_command_taken), 64'd1);
            @(posedge clk);
        end
        #1;
        bus.oc_write_command_ready_length = 8'd0;
        #1;
        chk("dfill_cr2", 64'(bus.data_credits), 64'd2);
        chk("dfill_len0", 64'(bus.oc_write_command_taken), 64'd1);
        cyc();
        bus.oc_write_command_ready_length = 8'd1;
        bus.tlx_cmd_credit_return         = 1'b0;
        bus.oc_read_command_ready_id      = 12'h011;
        bus.oc_read_command_ready         = 1'b1;
        #1;
        chk("dstall_cr1", 64'(bus.data_credits), 64'd1);
        chk("dstall_cmd8", 64'(bus.cmd_credits), 64'd8);
        chk("dstall_rd", 64'(bus.oc_read_command_taken), 64'd1);
        chk("dstall_wr", 64'(bus.oc_write_command_taken), 64'd0);
        cyc();
        bus.oc_read_command_ready = 1'b0;
        #1;
        chk("dstall_wr2", 64'(bus.oc_write_command_taken), 64'd0);
        chk("dstall_op", 64'(bus.tlx_cmd_opcode), 64'h20);
        bus.tlx_data_credit_return = 2'd1;
        cyc();
        bus.tlx_data_credit_return = 2'd0;
        #1;
        chk("dret_cr2", 64'(bus.data_credits), 64'd2);
        chk("dret_wr", 64'(bus.oc_write_command_taken), 64'd1);
        cyc();
        bus.oc_write_command_ready = 1'b0;
        #1;
        chk("dret_op", 64'(bus.tlx_cmd_opcode), 64'h81);
        chk("dret_data_cr", 64'(bus.data_credits), 64'd0);
        chk("dret_cmd_cr", 64'(bus.cmd_credits), 64'd6);

        // illegal read size
        bus.oc_read_command_ready_size = 3'd5;
        bus.oc_read_command_ready      = 1'b1;
        #1;
        chk("ill_taken", 64'(bus.oc_read_command_taken), 64'd1);
        cyc();
        bus.oc_read_command_ready      = 1'b0;
        bus.oc_read_command_ready_size = 3'd6;
        #1;
        chk("ill_err", 64'(bus.cmd_error), 64'd1);
        chk("ill_valid", 64'(bus.tlx_cmd_valid), 64'd0);
        chk("ill_cmd_cr", 64'(bus.cmd_credits), 64'd6);
        cyc();
        chk("ill_err_off", 64'(bus.cmd_error), 64'd0);

        // stall with tlx_cmd_ready low; returns still counted
        bus.tlx_cmd_ready                 = 1'b0;
        bus.oc_read_command_ready_id      = 12'h033;
        bus.oc_read_command_ready_address = 64'h3000;
        bus.oc_read_command_ready         = 1'b1;
        #1;
        chk("stl_taken", 64'(bus.oc_read_command_taken), 64'd1);
        cyc();
        bus.oc_read_command_ready_id      = 12'h044;
        bus.oc_read_command_ready_address = 64'h4000;
        bus.tlx_cmd_credit_return         = 1'b1;
        #1;
        chk("stl_valid", 64'(bus.tlx_cmd_valid), 64'd1);
        chk("stl_no_take", 64'(bus.oc_read_command_taken), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.tlx_cmd_credit_return = 1'b0;
            #1;
            chk($sformatf("stl_tag%0d", i), 64'(bus.tlx_cmd_capptag), 64'h0033);
            chk($sformatf("stl_ea%0d", i), 64'(bus.tlx_cmd_ea), 64'h3000);
            chk($sformatf("stl_vld%0d", i), 64'(bus.tlx_cmd_valid), 64'd1);
            chk($sformatf("stl_take%0d", i), 64'(bus.oc_read_command_taken), 64'd0);
        end
        chk("stl_cmd_cr", 64'(bus.cmd_credits), 64'd6);

        // async reset mid-stall
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.tlx_cmd_valid), 64'd0);
        chk("arst_cmd_cr", 64'(bus.cmd_credits), 64'd8);
        chk("arst_data_cr", 64'(bus.data_credits), 64'd16);
        chk("arst_taken", 64'(bus.oc_read_command_taken), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
